// File: rtl/ffa_if.sv
// ffa_if: request/response bundle for the GF(2^255-19) modular adder.
//   start  : request strobe, sampled by the adder only while it is idle
//   a, b   : 255-bit canonical addends
//   result : (a + b) mod P, held until the next completion
//   valid  : one-cycle completion pulse
//   busy   : operation in flight
// master = requester (sequencer / bench), slave = the adder.
interface ffa_if;
  logic         start;
  logic [254:0] a;
  logic [254:0] b;
  logic [254:0] result;
  logic         valid;
  logic         busy;

  modport master (output start, output a, output b,
                  input  result, input valid, input busy);
  modport slave  (input  start, input a, input b,
                  output result, output valid, output busy);
endinterface

// File: rtl/ffa.sv
// ffa: sequential modular adder over GF(P), P = 2^255 - 19.
// Computes (a + b) mod P one LIMB_W-bit limb per cycle, least-significant
// limb first. A sum chain (a + b) and a trial-reduction chain (sum - P) run
// side by side; the final borrow of the trial chain picks which one is the
// reduced result. Latency is NL = 256/LIMB_W cycles from the accepting edge.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ffa_if.slave (start/a/b in, result/valid/busy out)
module ffa #(
  parameter int LIMB_W = 64
) (
  input  logic  clk,
  input  logic  rst_n,
  ffa_if.slave  bus
);

  localparam int NL = 256 / LIMB_W;
  localparam int IW = (NL > 1) ? $clog2(NL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NL - 1);
  localparam logic [255:0]  P_C = (256'd1 << 255) - 256'd19;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            borrow_q, borrow_d;
  logic [255:0]    a_q, a_d;
  logic [255:0]    b_q, b_d;
  logic [255:0]    sum_q, sum_d;
  logic [255:0]    diff_q, diff_d;
  logic [254:0]    result_q, result_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic [8:0]      off_s;
  logic [LIMB_W:0] s_ext_s;
  logic [LIMB_W:0] t_ext_s;

  // Limb datapath: this cycle's sum limb and its trial subtraction of P.
  always_comb begin
    off_s   = 9'(idx_q) * 9'(LIMB_W);
    s_ext_s = {1'b0, a_q[off_s +: LIMB_W]} + {1'b0, b_q[off_s +: LIMB_W]}
            + {{LIMB_W{1'b0}}, carry_q};
    // The subtraction uses the fresh sum limb, not the registered one, so both
    // chains finish on the same edge. Top bit of the result is the borrow-out.
    t_ext_s = {1'b0, s_ext_s[LIMB_W-1:0]} - {1'b0, P_C[off_s +: LIMB_W]}
            - {{LIMB_W{1'b0}}, borrow_q};
  end

  // Next-state and output logic of the IDLE/RUN controller.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    diff_d   = diff_q;
    result_d = result_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = {1'b0, bus.a};
          b_d      = {1'b0, bus.b};
          idx_d    = '0;
          carry_d  = 1'b0;
          borrow_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        sum_d[off_s +: LIMB_W]  = s_ext_s[LIMB_W-1:0];
        diff_d[off_s +: LIMB_W] = t_ext_s[LIMB_W-1:0];
        carry_d  = s_ext_s[LIMB_W];
        borrow_d = t_ext_s[LIMB_W];
        idx_d    = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          // No final borrow means sum >= P, so the reduced value is sum - P.
          // The sum carry-out is zero for canonical inputs and is dropped.
          result_d = borrow_d ? sum_d[254:0] : diff_d[254:0];
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d  = RUN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      a_q      <= 256'd0;
      b_q      <= 256'd0;
      sum_q    <= 256'd0;
      diff_q   <= 256'd0;
      result_q <= 255'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      diff_q   <= diff_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result = result_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_ffa.sv
// tb_ffa: directed self-checking bench for ffa (LIMB_W = 64, NL = 4).
// Expected sums come from a 256-bit reference model, queued when a request
// is driven and popped when the adder pulses valid.
module tb_ffa;

  localparam int           NL  = 4;
  localparam logic [255:0] P_C = (256'd1 << 255) - 256'd19;

  logic clk;
  logic rst_n;
  ffa_if bus ();

  ffa #(.LIMB_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks;
  int failures;
  logic [254:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [254:0] model(input logic [254:0] x, input logic [254:0] y);
    logic [255:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= P_C) s = s - P_C;
    return s[254:0];
  endfunction

  function automatic logic [254:0] rand_canon();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    r[255] = 1'b0;
    if (r >= P_C) r = r - P_C;
    return r[254:0];
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One request; optionally disturbs inputs and pulses start mid-flight.
  task automatic run_op(input logic [254:0] a_in, input logic [254:0] b_in,
                        input logic disturb, input string tag);
    int busy_cnt;
    logic seen;
    logic [254:0] expv;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a_in; bus.b = b_in;
    exp_q.push_back(model(a_in, b_in));
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (bus.valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus.busy === 1'b1) busy_cnt++;
        if (disturb) begin
          bus.start = (busy_cnt == 2);
          if (busy_cnt == 2) begin
            bus.a = ~a_in;
            bus.b = rand_canon();
          end
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    check({tag, " valid_seen"}, 256'(seen), 256'd1);
    expv = exp_q.pop_front();
    check({tag, " result"}, 256'(bus.result), 256'(expv));
    check({tag, " busy_cycles"}, 256'(busy_cnt), 256'(NL));
    check({tag, " busy_at_valid"}, 256'(bus.busy), 256'd0);
    @(negedge clk);
    check({tag, " valid_one_cycle"}, 256'(bus.valid), 256'd0);
    check({tag, " idle_after"}, 256'(bus.busy), 256'd0);
  endtask

  initial begin
    logic [254:0] pm1;
    logic [254:0] expv;
    logic         vseen;
    int           cnt;
    checks = 0;
    failures = 0;
    pm1 = P_C[254:0] - 255'd1;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = 255'd0;
    bus.b = 255'd0;
    #12;
    check("reset result", 256'(bus.result), 256'd0);
    check("reset valid", 256'(bus.valid), 256'd0);
    check("reset busy", 256'(bus.busy), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(255'd1, 255'd2, 1'b0, "basic");
    check("basic const", 256'(bus.result), 256'd3);
    run_op(pm1, 255'd1, 1'b0, "wrap0");
    check("wrap0 const", 256'(bus.result), 256'd0);
    run_op(pm1, pm1, 1'b0, "max");
    check("max const", 256'(bus.result), P_C - 256'd2);
    run_op(255'((256'd1 << 64) - 256'd1), 255'd1, 1'b0, "carry64");
    check("carry64 const", 256'(bus.result), 256'd1 << 64);
    run_op(255'((256'd1 << 192) - 256'd1), 255'd1, 1'b0, "carry192");
    check("carry192 const", 256'(bus.result), 256'd1 << 192);
    run_op(255'(P_C - 256'd10), 255'd20, 1'b0, "wrap10");
    check("wrap10 const", 256'(bus.result), 256'd10);
    for (int i = 0; i < 4; i++) run_op(rand_canon(), rand_canon(), 1'b0, "random");
    run_op(rand_canon(), rand_canon(), 1'b1, "disturb");

    // Start held high: one result every NL+1 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 255'd5; bus.b = 255'd6;
    for (int k = 0; k < 3; k++) exp_q.push_back(model(255'd5, 255'd6));
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      vseen = 1'b0;
      while (!vseen && cnt < 20) begin
        @(negedge clk);
        cnt++;
        if (bus.valid === 1'b1) vseen = 1'b1;
      end
      if (k == 2) bus.start = 1'b0;
      check("stream gap", 256'(cnt), 256'(NL + 1));
      expv = exp_q.pop_front();
      check("stream result", 256'(bus.result), 256'(expv));
    end
    @(negedge clk);
    check("stream stop busy", 256'(bus.busy), 256'd0);

    // Reset two cycles into an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 255'd100; bus.b = 255'd200;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort result", 256'(bus.result), 256'd0);
    check("abort valid", 256'(bus.valid), 256'd0);
    check("abort busy", 256'(bus.busy), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vseen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0) vseen = 1'b1;
    end
    check("post abort quiet", 256'(vseen), 256'd0);
    run_op(255'd7, 255'd8, 1'b0, "after_reset");
    check("after_reset const", 256'(bus.result), 256'd15);
    check("queue drained", 256'(exp_q.size()), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
